// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM states and fetch constants.
package instruction_fetch_pkg;
  typedef enum logic [1:0] {WARMUP, RUN, FAULT} fetch_state_e;

  localparam logic [15:0] NOP     = 16'h0000;
  localparam logic [15:0] PC_STEP = 16'd2;
endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: loads on capture, drops valid on squash, otherwise holds.
module if_id_register
  import instruction_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        capture,
  input  logic        squash,
  input  logic [15:0] instruction,
  input  logic [15:0] pc,
  output logic [15:0] if_id_instruction,
  output logic [15:0] if_id_pc,
  output logic        if_id_valid
);

  // Squash only invalidates; the payload keeps its last captured value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_instruction <= NOP;
      if_id_pc          <= '0;
      if_id_valid       <= 1'b0;
    end else if (squash) begin
      if_id_valid <= 1'b0;
    end else if (capture) begin
      if_id_instruction <= instruction;
      if_id_pc          <= pc;
      if_id_valid       <= 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC register, WARMUP/RUN/FAULT FSM and IF/ID register.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_TRAP_EN.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter int unsigned MEM_BYTES = 128
) (
  input  logic        Clock,
  input  logic        ResetN,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [15:0] BranchTarget,
  input  logic [15:0] Instruction,
  output logic [15:0] PCAddress,
  output logic [15:0] IfIdInstruction,
  output logic [15:0] IfIdPC,
  output logic        IfIdValid,
  output logic        FetchFault
);

  fetch_state_e state, state_next;
  logic [15:0]  pc_next;
  logic [15:0]  target;
  logic         misaligned;
  logic         capture;
  logic         squash;

  function automatic logic [15:0] wrap_addr(input logic [16:0] addr);
    logic [31:0] m;
    m = {15'b0, addr} % MEM_BYTES;
    return m[15:0];
  endfunction

  assign target = BranchTarget & ~16'h0001;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign misaligned = BranchTaken & BranchTarget[0];
  // FAULT is exited only by reset, so the state itself is the sticky flag.
  assign FetchFault = (state == FAULT);
`else
  assign misaligned = 1'b0;
  assign FetchFault = 1'b0;
`endif

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      state     <= WARMUP;
      PCAddress <= RESET_PC;
    end else begin
      state     <= state_next;
      PCAddress <= pc_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      WARMUP:  state_next = misaligned ? FAULT : RUN;
      RUN:     state_next = misaligned ? FAULT : RUN;
      FAULT:   state_next = FAULT;
      default: state_next = WARMUP;
    endcase
  end

  always_comb begin
    pc_next = PCAddress;
    capture = 1'b0;
    squash  = 1'b0;
    case (state)
      WARMUP: begin
        if (BranchTaken) begin
          squash = 1'b1;
          if (!misaligned) pc_next = wrap_addr({1'b0, target});
        end
      end
      RUN: begin
        if (BranchTaken) begin
          squash = 1'b1;
          if (!misaligned) pc_next = wrap_addr({1'b0, target});
        end else if (!Stall) begin
          capture = 1'b1;
          pc_next = wrap_addr({1'b0, PCAddress} + {1'b0, PC_STEP});
        end
      end
      FAULT:   squash = 1'b1;
      default: squash = 1'b1;
    endcase
  end

  if_id_register u_if_id (
    .clk               (Clock),
    .rst_n             (ResetN),
    .capture           (capture),
    .squash            (squash),
    .instruction       (Instruction),
    .pc                (PCAddress),
    .if_id_instruction (IfIdInstruction),
    .if_id_pc          (IfIdPC),
    .if_id_valid       (IfIdValid)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: behavioural model plus directed literal checks.
module tb_instruction_fetch;
  localparam int unsigned MEM = 128;
`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        Clock = 1'b0;
  logic        ResetN, Stall, BranchTaken;
  logic [15:0] BranchTarget, Instruction, PCAddress, IfIdInstruction, IfIdPC;
  logic        IfIdValid, FetchFault;

  logic [15:0] mem [64];
  int total = 0;
  int bad = 0;

  always #5 Clock = ~Clock;
  assign Instruction = mem[PCAddress[6:1]];

  instruction_fetch #(.RESET_PC(16'h0000), .MEM_BYTES(MEM)) dut (
    .Clock(Clock), .ResetN(ResetN), .Stall(Stall), .BranchTaken(BranchTaken),
    .BranchTarget(BranchTarget), .Instruction(Instruction), .PCAddress(PCAddress),
    .IfIdInstruction(IfIdInstruction), .IfIdPC(IfIdPC), .IfIdValid(IfIdValid),
    .FetchFault(FetchFault)
  );

  // Reference model: the fetch rules applied directly to plain variables.
  logic [15:0] m_pc, m_ins, m_ipc;
  logic        m_valid, m_fault, m_warm;

  always @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      m_pc = 16'h0000; m_ins = 16'h0000; m_ipc = 16'h0000;
      m_valid = 1'b0; m_fault = 1'b0; m_warm = 1'b1;
    end else if (m_fault) begin
      m_valid = 1'b0;
    end else if (BranchTaken) begin
      m_valid = 1'b0;
      m_warm  = 1'b0;
      if (TRAP && BranchTarget[0]) m_fault = 1'b1;
      else m_pc = 16'((int'(BranchTarget) / 2 * 2) % MEM);
    end else if (m_warm) begin
      m_warm = 1'b0;
    end else if (!Stall) begin
      m_ins   = mem[(int'(m_pc) % MEM) / 2];
      m_ipc   = m_pc;
      m_valid = 1'b1;
      m_pc    = 16'((int'(m_pc) + 2) % MEM);
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clock) begin
    check("model_pc",    PCAddress,        m_pc);
    check("model_ins",   IfIdInstruction,  m_ins);
    check("model_ipc",   IfIdPC,           m_ipc);
    check("model_valid", 16'(IfIdValid),   16'(m_valid));
    check("model_fault", 16'(FetchFault),  16'(m_fault));
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pc"},    PCAddress,       16'h0000);
    check({tag, "_ins"},   IfIdInstruction, 16'h0000);
    check({tag, "_ipc"},   IfIdPC,          16'h0000);
    check({tag, "_valid"}, 16'(IfIdValid),  16'h0000);
    check({tag, "_fault"}, 16'(FetchFault), 16'h0000);
  endtask

  task automatic startup_sequence(input string tag);
    step();
    check({tag, "_warm_valid"}, 16'(IfIdValid), 16'h0000);
    check({tag, "_warm_pc"},    PCAddress,      16'h0000);
    step();
    check({tag, "_f0_ins"},   IfIdInstruction, 16'h1111);
    check({tag, "_f0_ipc"},   IfIdPC,          16'h0000);
    check({tag, "_f0_valid"}, 16'(IfIdValid),  16'h0001);
    step();
    check({tag, "_f1_ins"}, IfIdInstruction, 16'h2222);
    check({tag, "_f1_ipc"}, IfIdPC,          16'h0002);
    check({tag, "_f1_pc"},  PCAddress,       16'h0004);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'hA000 + 16'(i);
    mem[0] = 16'h1111;
    mem[1] = 16'h2222;
    ResetN = 1'b0; Stall = 1'b0; BranchTaken = 1'b0; BranchTarget = 16'h0000;
    step(); step();
    check_reset_vals("reset");
    ResetN = 1'b1;
    startup_sequence("start");

    // Stall three edges at PC 0x0004, then resume.
    Stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("stall_pc",  PCAddress,       16'h0004);
      check("stall_ins", IfIdInstruction, 16'h2222);
      check("stall_ipc", IfIdPC,          16'h0002);
    end
    Stall = 1'b0;
    step();
    check("resume_pc",  PCAddress,       16'h0006);
    check("resume_ins", IfIdInstruction, 16'hA002);

    // Redirect wins over stall.
    BranchTaken = 1'b1; Stall = 1'b1; BranchTarget = 16'h0040;
    step();
    check("br_pc",    PCAddress,       16'h0040);
    check("br_valid", 16'(IfIdValid),  16'h0000);
    check("br_ins",   IfIdInstruction, 16'hA002);
    check("br_ipc",   IfIdPC,          16'h0004);
    BranchTaken = 1'b0; Stall = 1'b0;
    step();
    check("br_cap_ins", IfIdInstruction, 16'hA020);
    check("br_cap_ipc", IfIdPC,          16'h0040);

    // Wrap from MEM_BYTES-2 back to zero.
    BranchTaken = 1'b1; BranchTarget = 16'h007C;
    step();
    BranchTaken = 1'b0;
    step();
    check("pre_wrap_pc", PCAddress, 16'h007E);
    step();
    check("wrap_pc",  PCAddress,       16'h0000);
    check("wrap_ins", IfIdInstruction, 16'hA03F);
    check("wrap_ipc", IfIdPC,          16'h007E);

    // Reset mid-stream at PC 0x0010, with a pending stall+redirect discarded.
    BranchTaken = 1'b1; BranchTarget = 16'h000C;
    step();
    BranchTaken = 1'b0;
    step(); step();
    check("pre_rst_pc", PCAddress, 16'h0010);
    ResetN = 1'b0;
    #1;
    check_reset_vals("async_rst");
    Stall = 1'b1; BranchTaken = 1'b1; BranchTarget = 16'h0030;
    step();
    check_reset_vals("held_rst");
    Stall = 1'b0; BranchTaken = 1'b0;
    ResetN = 1'b1;
    startup_sequence("restart");

    // Misaligned redirect.
    BranchTaken = 1'b1; BranchTarget = 16'h0041;
    step();
    BranchTaken = 1'b0;
    if (TRAP) begin
      check("trap_fault", 16'(FetchFault), 16'h0001);
      check("trap_pc",    PCAddress,       16'h0004);
      check("trap_valid", 16'(IfIdValid),  16'h0000);
      step(); step();
      check("trap_hold_pc",    PCAddress,      16'h0004);
      check("trap_hold_valid", 16'(IfIdValid), 16'h0000);
    end else begin
      check("mis_pc",    PCAddress,       16'h0040);
      check("mis_fault", 16'(FetchFault), 16'h0000);
      step();
      check("mis_ins", IfIdInstruction, 16'hA020);
    end
    ResetN = 1'b0;
    step();
    check_reset_vals("post_mis_rst");
    ResetN = 1'b1;

    // Redirect during WARMUP still loads the PC.
    BranchTaken = 1'b1; BranchTarget = 16'h0020;
    step();
    check("warm_br_pc",    PCAddress,      16'h0020);
    check("warm_br_valid", 16'(IfIdValid), 16'h0000);
    BranchTaken = 1'b0;
    step();
    check("warm_br_ins", IfIdInstruction, 16'hA010);
    check("warm_br_ipc", IfIdPC,          16'h0020);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
